// File: rtl/adder_result_checker.sv
// -----------------------------------------------------------------------------
// adder_result_checker
//
// Synthesizable in-order result checker for the adder output port pair
// (o / valid_out). Expected sums are preloaded into an internal circular
// FIFO while IDLE. After start, each valid adder result is compared against
// the FIFO head. The outcome is reported through registered status outputs.
//
// Optional feature macro: ADDER_CHECKER_TIMEOUT_EN
//   defined   : RUN fails with timeout=1 after TIMEOUT cycles without finishing
//   undefined : no timeout counter, timeout tied to 0, RUN waits indefinitely
//
// Parameters
//   BITS    : data width of adder result and expected value
//   DEPTH   : expected-value FIFO depth (power of two, >= 2)
//   TIMEOUT : cycles allowed in RUN before a timeout failure
//
// Ports
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   clear        : synchronous flush of FIFO, status and counters; back to IDLE
//   exp_valid    : push request for exp_data (accepted when exp_ready)
//   exp_data     : expected sum
//   exp_ready    : high in IDLE while the FIFO is not full
//   start        : arm the checker (honoured only in IDLE)
//   valid_out    : adder result valid
//   o            : adder result
//   done         : state is PASS or FAIL
//   pass         : state is PASS
//   fail         : state is FAIL
//   timeout      : the failure was caused by the timeout
//   err_expected : expected value at the first failure
//   err_actual   : adder result at the first failure
//   checked_cnt  : matched results, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module adder_result_checker #(
    parameter int BITS    = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 400
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clear,
    input  logic            exp_valid,
    input  logic [BITS-1:0] exp_data,
    output logic            exp_ready,
    input  logic            start,
    input  logic            valid_out,
    input  logic [BITS-1:0] o,
    output logic            done,
    output logic            pass,
    output logic            fail,
    output logic            timeout,
    output logic [BITS-1:0] err_expected,
    output logic [BITS-1:0] err_actual,
    output logic [15:0]     checked_cnt
);

    // state | meaning
    // IDLE  | accepting expected values, waiting for start
    // RUN   | comparing each valid result against the FIFO head
    // PASS  | every expected value matched (terminal)
    // FAIL  | mismatch, underflow or timeout (terminal)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam int AW = $clog2(DEPTH);

    state_t state, state_nxt;

    logic [BITS-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [AW:0]     rd_ptr_inc;
    logic            empty;
    logic            full;
    logic            last_entry;
    logic [BITS-1:0] head;

    logic            push;
    logic            pop;
    logic            cnt_inc;
    logic            cap_err;
    logic [BITS-1:0] cap_exp;

    // -------------------------------------------------------------------------
    // FIFO status: pointers carry one extra wrap bit so full and empty differ.
    // -------------------------------------------------------------------------
    assign rd_ptr_inc = rd_ptr + {{AW{1'b0}}, 1'b1};
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign last_entry = (rd_ptr_inc == wr_ptr);
    assign head       = mem[rd_ptr[AW-1:0]];

    assign exp_ready  = (state == S_IDLE) && !full;
    assign done       = (state == S_PASS) || (state == S_FAIL);
    assign pass       = (state == S_PASS);
    assign fail       = (state == S_FAIL);

    // -------------------------------------------------------------------------
    // Timeout counter (optional)
    // -------------------------------------------------------------------------
`ifdef ADDER_CHECKER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmr;
    logic          tmr_hit;
    logic          cap_to;

    // Counter is held at 0 in IDLE so the first RUN cycle sees 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr <= '0;
        end else if (clear || (state != S_RUN)) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign tmr_hit = (state == S_RUN) && (tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout <= 1'b0;
        end else if (clear) begin
            timeout <= 1'b0;
        end else if (cap_err) begin
            timeout <= cap_to;
        end
    end
`else
    assign timeout = 1'b0;

    // TIMEOUT only matters when the timeout feature is built in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        cnt_inc   = 1'b0;
        cap_err   = 1'b0;
        cap_exp   = '0;
`ifdef ADDER_CHECKER_TIMEOUT_EN
        cap_to    = 1'b0;
`endif
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    push = exp_valid && exp_ready;
                    if (start) begin
                        state_nxt = empty ? S_PASS : S_RUN;
                    end
                end
                S_RUN: begin
                    if (valid_out && empty) begin
                        // Result with nothing left to compare against.
                        state_nxt = S_FAIL;
                        cap_err   = 1'b1;
                        cap_exp   = '0;
                    end else if (valid_out && (head != o)) begin
                        pop       = 1'b1;
                        state_nxt = S_FAIL;
                        cap_err   = 1'b1;
                        cap_exp   = head;
                    end else if (valid_out && last_entry) begin
                        // A completing match beats a same-cycle timeout.
                        pop       = 1'b1;
                        cnt_inc   = 1'b1;
                        state_nxt = S_PASS;
                    end else begin
                        if (valid_out) begin
                            pop     = 1'b1;
                            cnt_inc = 1'b1;
                        end
`ifdef ADDER_CHECKER_TIMEOUT_EN
                        if (tmr_hit) begin
                            state_nxt = S_FAIL;
                            cap_err   = 1'b1;
                            cap_exp   = head;
                            cap_to    = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (no reset needed; pointers define validity)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= exp_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, counters and captured failure data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            checked_cnt  <= '0;
            err_expected <= '0;
            err_actual   <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            checked_cnt  <= '0;
            err_expected <= '0;
            err_actual   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (cnt_inc && (checked_cnt != 16'hFFFF)) begin
                checked_cnt <= checked_cnt + 16'd1;
            end
            if (cap_err) begin
                err_expected <= cap_exp;
                err_actual   <= o;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;

    logic        clk;
    logic        resetn;
    logic        clear;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_ready;
    logic        start;
    logic        valid_out;
    logic [15:0] o;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [15:0] err_expected;
    logic [15:0] err_actual;
    logic [15:0] checked_cnt;

    int n_checks;
    int n_fails;

    logic [15:0] vec4 [4];
    logic [15:0] vec8 [8];

    adder_result_checker #(
        .BITS    (16),
        .DEPTH   (8),
        .TIMEOUT (400)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (clear),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .exp_ready    (exp_ready),
        .start        (start),
        .valid_out    (valid_out),
        .o            (o),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .err_expected (err_expected),
        .err_actual   (err_actual),
        .checked_cnt  (checked_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic push_one(input logic [15:0] v);
        exp_valid = 1'b1;
        exp_data  = v;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic result(input logic [15:0] v);
        valid_out = 1'b1;
        o         = v;
        tick();
        valid_out = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        resetn    = 1'b0;
        clear     = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        start     = 1'b0;
        valid_out = 1'b0;
        o         = '0;
        vec4 = '{16'ha8af, 16'h93eb, 16'hab5b, 16'h78a6};
        vec8 = '{16'h1001, 16'h2002, 16'h3003, 16'h4004,
                 16'h5005, 16'h6006, 16'h7007, 16'h8008};

        tick();
        tick();
        chk("rst_exp_ready", exp_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_exp", err_expected, 0);
        chk("rst_err_act", err_actual, 0);
        chk("rst_cnt", checked_cnt, 0);
        resetn = 1'b1;
        tick();

        // ---- all match, back-to-back ----
        for (int i = 0; i < 4; i++) begin
            exp_valid = 1'b1;
            exp_data  = vec4[i];
            tick();
        end
        exp_valid = 1'b0;
        do_start();
        chk("run_exp_ready", exp_ready, 0);
        chk("run_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            valid_out = 1'b1;
            o         = vec4[i];
            tick();
            if (i == 2) chk("match_not_done_yet", done, 0);
        end
        valid_out = 1'b0;
        chk("match_pass", pass, 1);
        chk("match_done", done, 1);
        chk("match_fail", fail, 0);
        chk("match_cnt", checked_cnt, 4);

        // ---- mismatch on 2nd result ----
        do_clear();
        chk("clear_done", done, 0);
        for (int i = 0; i < 4; i++) push_one(vec4[i]);
        do_start();
        result(16'ha8af);
        chk("mm_cnt_first", checked_cnt, 1);
        result(16'h93ec);
        chk("mm_fail", fail, 1);
        chk("mm_pass", pass, 0);
        chk("mm_err_exp", err_expected, 16'h93eb);
        chk("mm_err_act", err_actual, 16'h93ec);
        chk("mm_cnt", checked_cnt, 1);
        chk("mm_timeout", timeout, 0);
        result(16'hab5b);
        chk("mm_hold_fail", fail, 1);
        chk("mm_hold_err_exp", err_expected, 16'h93eb);
        chk("mm_hold_err_act", err_actual, 16'h93ec);
        chk("mm_hold_cnt", checked_cnt, 1);

        // ---- clear together with start after FAIL ----
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("cs_done", done, 0);
        chk("cs_fail", fail, 0);
        chk("cs_cnt", checked_cnt, 0);
        chk("cs_err_exp", err_expected, 0);
        chk("cs_exp_ready", exp_ready, 1);
        do_start();
        chk("cs_empty_pass", pass, 1);
        chk("cs_empty_cnt", checked_cnt, 0);

        // ---- full FIFO ----
        do_clear();
        for (int i = 0; i < 8; i++) begin
            push_one(vec8[i]);
            if (i == 6) chk("full_ready_7", exp_ready, 1);
        end
        chk("full_ready_8", exp_ready, 0);
        push_one(16'hdead);
        chk("full_ready_9", exp_ready, 0);
        do_start();
        for (int i = 0; i < 8; i++) begin
            result(vec8[i]);
            if (i == 6) chk("full_not_done", done, 0);
        end
        chk("full_pass", pass, 1);
        chk("full_cnt", checked_cnt, 8);
        result(16'hdead);
        chk("full_extra_pass", pass, 1);
        chk("full_extra_fail", fail, 0);
        chk("full_extra_cnt", checked_cnt, 8);

        // ---- single entry, valid_out in IDLE ignored, extra result ignored ----
        do_clear();
        push_one(16'h1234);
        result(16'h1234);
        chk("idle_valid_cnt", checked_cnt, 0);
        chk("idle_valid_done", done, 0);
        do_start();
        chk("one_run", done, 0);
        result(16'h1234);
        chk("one_pass", pass, 1);
        chk("one_cnt", checked_cnt, 1);
        result(16'h1234);
        chk("one_extra_pass", pass, 1);
        chk("one_extra_fail", fail, 0);
        chk("one_extra_cnt", checked_cnt, 1);

        // ---- empty start ----
        do_clear();
        do_start();
        chk("empty_pass", pass, 1);
        chk("empty_done", done, 1);
        chk("empty_cnt", checked_cnt, 0);

        // ---- asynchronous reset mid-RUN ----
        do_clear();
        push_one(16'h0111);
        push_one(16'h0222);
        do_start();
        result(16'h0111);
        chk("rr_cnt_before", checked_cnt, 1);
        chk("rr_ready_before", exp_ready, 0);
        resetn = 1'b0;
        #1;
        chk("rr_cnt", checked_cnt, 0);
        chk("rr_exp_ready", exp_ready, 1);
        chk("rr_done", done, 0);
        tick();
        resetn = 1'b1;
        tick();
        do_start();
        chk("rr_fifo_discarded", pass, 1);

        // ---- timeout ----
`ifdef ADDER_CHECKER_TIMEOUT_EN
        do_clear();
        push_one(16'h0abc);
        o = 16'h7777;
        do_start();
        repeat (399) tick();
        chk("to_still_run", done, 0);
        tick();
        chk("to_fail", fail, 1);
        chk("to_flag", timeout, 1);
        chk("to_err_exp", err_expected, 16'h0abc);
        chk("to_err_act", err_actual, 16'h7777);

        do_clear();
        chk("to_clear_flag", timeout, 0);
        push_one(16'h0abc);
        do_start();
        repeat (399) tick();
        result(16'h0abc);
        chk("to_race_pass", pass, 1);
        chk("to_race_flag", timeout, 0);
        chk("to_race_cnt", checked_cnt, 1);
`else
        do_clear();
        push_one(16'h0abc);
        do_start();
        repeat (450) tick();
        chk("nto_still_run", done, 0);
        chk("nto_flag", timeout, 0);
        result(16'h0abc);
        chk("nto_pass", pass, 1);
        chk("nto_cnt", checked_cnt, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

- Synthesizable result checker that sits on the output side of the `adder` (its `o` / `valid_out` port pair).
- Software or a stimulus block preloads the expected sums into an internal FIFO. The checker is then armed and compares every valid adder result against the FIFO head, in order.
- It reports pass, fail, mismatch data and timeout through registered status outputs.
- It replaces the simulation-only queue checker so the same self-check can run in emulation and on FPGA.

## Interface
- `BITS`, 16, data width of adder result and expected value
- `DEPTH`, 8, expected-value FIFO depth (power of two, ≥2)
- `TIMEOUT`, 400, cycles allowed in RUN before timeout failure
- `clk` input 1 — clock; all logic on rising edge
- `resetn` input 1 — asynchronous active-low reset
- `clear` input 1 — synchronous: flush FIFO, zero status and counters, go to IDLE
- `exp_valid` input 1 — push `exp_data` into FIFO when `exp_ready` is high
- `exp_data` input BITS — expected sum
- `exp_ready` output 1 — high in IDLE with FIFO not full
- `start` input 1 — arm checker; honoured only in IDLE
- `valid_out` input 1 — adder result valid
- `o` input BITS — adder result
- `done` output 1 — state is PASS or FAIL
- `pass` output 1 — state is PASS
- `fail` output 1 — state is FAIL
- `timeout` output 1 — failure cause was timeout
- `err_expected` output BITS — expected value at first failure
- `err_actual` output BITS — `o` at first failure
- `checked_cnt` output 16 — number of matched results; saturates at 0xFFFF

## Operation
- **Reset values:** all outputs are 0 and `exp_ready` is 1. The FIFO is empty and the state is IDLE.
- **States:** IDLE, RUN, PASS, FAIL.
- **IDLE**
  - A push is accepted when `exp_valid && exp_ready`.
  - `start` moves to RUN.
  - If the FIFO is empty at `start`, the state moves directly to PASS with `checked_cnt` = 0.
- **RUN**
  - Pushes are ignored and `exp_ready` = 0.
  - On `valid_out`, the FIFO head is popped and compared with `o`.
  - On a match, `checked_cnt` increments. If the FIFO is now empty, the state moves to PASS.
  - On a mismatch, the state moves to FAIL. `err_expected` captures the head and `err_actual` captures `o`.
  - If `valid_out` arrives with the FIFO empty, the state moves to FAIL with `err_expected` = 0 and `err_actual` = `o`.
- **PASS / FAIL**
  - Both are terminal. `valid_out` is ignored and all status holds until `clear` or reset.
- **`valid_out` outside RUN:** ignored and nothing is popped.
- **FIFO:** circular buffer with log2(DEPTH)+1-bit read and write pointers.
  - Full when the pointers differ only in their MSB.
  - A push when full is impossible because `exp_ready` = 0.
  - Pointers wrap modulo 2·DEPTH.
- **`clear`:** has priority over every other input in the same cycle.
- **`start` with `clear`:** when both are high, `clear` wins and the state remains IDLE.

## Timing
- **Compare latency:** a compare happens on the rising edge where `valid_out` is sampled high. Status becomes visible on the following cycle, i.e. 1-cycle latency.
- **Back-to-back results:** `valid_out` may be high every cycle, and one result is consumed per cycle.
- **Start latency:** `start` sampled in IDLE gives RUN on the next cycle, and the timeout counter starts at 0.
- **Timeout counter:** counts cycles spent in RUN. When the count reaches `TIMEOUT`−1 while still in RUN, the next state is FAIL with `timeout` = 1. The `err_*` fields hold the FIFO head and the current `o`.
- **Timeout vs. compare in the same cycle:** the compare result takes priority.
  - A completing match gives PASS.
  - A mismatch gives FAIL with `timeout` = 0.
- **Reset mid-RUN:** asynchronous return to reset values; FIFO contents are discarded.

## Configuration
- `ADDER_CHECKER_TIMEOUT_EN`
  - **Defined:** the timeout counter and timeout transition exist as described above.
  - **Undefined:** no counter is synthesized, `timeout` is tied to 0, and RUN waits indefinitely.
  - `TIMEOUT` is then unused.

## Test plan
- **All match:** push 0xa8af, 0x93eb, 0xab5b, 0x78a6, then start. Drive `valid_out` with `o` equal to those values, back-to-back.
  - Expect PASS one cycle after the 4th result.
  - Expect `checked_cnt` = 4, `fail` = 0.
- **Mismatch:** same preload, but the 2nd result is 0x93ec.
  - Expect FAIL with `err_expected` = 0x93eb, `err_actual` = 0x93ec, `checked_cnt` = 1.
  - A further `valid_out` leaves status unchanged.
- **Full FIFO and underflow:** push 8 values.
  - `exp_ready` drops after the 8th push, and a 9th push is ignored.
  - Start, then send 9 matching results: PASS after the 8th, and the 9th is ignored.
  - Separately, start with 1 entry and send a result of 0x1234 twice: PASS after the first, and the second is ignored.
  - Start with an empty FIFO: PASS one cycle after `start`.
- **Timeout** (macro defined, `TIMEOUT` = 400): push 1 value, start, never assert `valid_out`.
  - Expect FAIL with `timeout` = 1 exactly 400 cycles after RUN entry.
  - Repeat with a matching `valid_out` on cycle 399: expect PASS and `timeout` = 0.
- **Reset and clear mid-operation:**
  - Assert `resetn` low on a negedge clk while in RUN: outputs go to 0 immediately, `exp_ready` = 1.
  - After FAIL, pulse `clear` together with `start`: state is IDLE, FIFO is empty, `checked_cnt` = 0.
